// File: rtl/dmem_arb_if.sv
// Requester-side bus of the data-memory arbiter; one instance per port (CPU memory stage, loader).
interface dmem_arb_if #(
    parameter int ADDR_W = 15
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (output req, we, addr, size, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, size, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arb.sv
// Two-port arbiter in front of four byte-wide data-memory banks, one-cycle load return.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port B (loader) always wins.
module dmem_arb #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arb_if.slave         a_if,
    dmem_arb_if.slave         b_if,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    logic              w_win_b;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_any_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [2:0]        w_sel_size;
    logic [31:0]       w_sel_wdata;
    logic [1:0]        w_sel_off;
    logic              w_legal;
    logic              w_ok;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_ld_data;
    logic              w_a_rvalid;
    logic              w_b_rvalid;

    logic              r_ld_valid;
    owner_e            r_ld_owner;
    logic [1:0]        r_ld_off;
    size_e             r_ld_size;
    logic              r_a_err;
    logic              r_b_err;

    // w_win_b decides only the contested case; a lone requester always wins.
`ifdef DMEM_ARB_RR_EN
    owner_e r_last;

    assign w_win_b = (r_last == OWN_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_A;
        end else if (a_if.req && b_if.req) begin
            r_last <= w_b_gnt ? OWN_B : OWN_A;
        end
    end
`else
    assign w_win_b = 1'b1;
`endif

    assign w_b_gnt   = !rst && b_if.req && (!a_if.req || w_win_b);
    assign w_a_gnt   = !rst && a_if.req && !w_b_gnt;
    assign w_any_gnt = w_a_gnt || w_b_gnt;

    assign w_sel_we    = w_b_gnt ? b_if.we    : a_if.we;
    assign w_sel_addr  = w_b_gnt ? b_if.addr  : a_if.addr;
    assign w_sel_size  = w_b_gnt ? b_if.size  : a_if.size;
    assign w_sel_wdata = w_b_gnt ? b_if.wdata : a_if.wdata;
    assign w_sel_off   = w_sel_addr[1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_legal      = 1'b0;
        w_be         = 4'b0000;
        w_lane_wdata = w_sel_wdata;
        case (w_sel_size)
            SZ_B, SZ_BU: begin
                w_legal      = 1'b1;
                w_be         = 4'b0001 << w_sel_off;
                w_lane_wdata = {4{w_sel_wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                w_legal      = !w_sel_off[0];
                w_be         = w_sel_off[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{w_sel_wdata[15:0]}};
            end
            SZ_W: begin
                w_legal = (w_sel_off == 2'b00);
                w_be    = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Illegal accesses are still granted so the requester never stalls on them.
    assign w_ok      = w_any_gnt && w_legal;
    assign mem_re    = w_ok && !w_sel_we;
    assign mem_we    = w_ok && w_sel_we;
    assign mem_be    = w_ok ? w_be : 4'b0000;
    assign mem_addr  = w_any_gnt ? w_sel_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = (w_ok && w_sel_we) ? w_lane_wdata : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            r_ld_valid <= 1'b0;
            r_ld_owner <= OWN_A;
            r_ld_off   <= 2'b00;
            r_ld_size  <= SZ_W;
            r_a_err    <= 1'b0;
            r_b_err    <= 1'b0;
        end else begin
            r_ld_valid <= mem_re;
            r_ld_owner <= w_b_gnt ? OWN_B : OWN_A;
            r_ld_off   <= w_sel_off;
            r_ld_size  <= size_e'(w_sel_size);
            r_a_err    <= w_a_gnt && !w_legal;
            r_b_err    <= w_b_gnt && !w_legal;
        end
    end

    // Lane select and extension of the bank data returning for the tagged load.
    always_comb begin
        w_shift   = mem_rdata >> {r_ld_off, 3'b000};
        w_ld_data = w_shift;
        case (r_ld_size)
            SZ_B:    w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            SZ_BU:   w_ld_data = {24'h000000, w_shift[7:0]};
            SZ_H:    w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            SZ_HU:   w_ld_data = {16'h0000, w_shift[15:0]};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // Gating with rst discards a load still in flight when reset arrives.
    assign w_a_rvalid = r_ld_valid && !rst && (r_ld_owner == OWN_A);
    assign w_b_rvalid = r_ld_valid && !rst && (r_ld_owner == OWN_B);

    assign a_if.gnt    = w_a_gnt;
    assign b_if.gnt    = w_b_gnt;
    assign a_if.rvalid = w_a_rvalid;
    assign b_if.rvalid = w_b_rvalid;
    assign a_if.rdata  = w_a_rvalid ? w_ld_data : '0;
    assign b_if.rdata  = w_b_rvalid ? w_ld_data : '0;
    assign a_if.err    = r_a_err && !rst;
    assign b_if.err    = r_b_err && !rst;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed scenarios plus randomized traffic against a byte-level model.
// Build with +define+DMEM_ARB_RR_EN to check the round-robin variant.
module tb_dmem_arb;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(ADDR_W)) a_bus ();
    dmem_arb_if #(.ADDR_W(ADDR_W)) b_bus ();

    dmem_arb #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_if      (a_bus),
        .b_if      (b_bus),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Four byte-lane banks with one-cycle read latency.
    logic [31:0] bank [0:(1<<(ADDR_W-2))-1];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we && mem_be[i]) bank[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_re) mem_rdata <= bank[mem_addr];
    end

    // Reference model state: byte memory, owed responses, last contested winner.
    logic [7:0]  ref_mem [0:255];
    bit          m_last_b;
    bit          m_gnt [2];
    bit          m_rv  [2];
    bit          m_err [2];
    logic [31:0] m_rd  [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port_b, input bit rq, input bit we,
                         input logic [ADDR_W-1:0] ad, input logic [2:0] sz, input logic [31:0] wd);
        if (port_b) begin
            b_bus.req = rq; b_bus.we = we; b_bus.addr = ad; b_bus.size = sz; b_bus.wdata = wd;
        end else begin
            a_bus.req = rq; a_bus.we = we; a_bus.addr = ad; a_bus.size = sz; a_bus.wdata = wd;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 'h10, 3'b010, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 'h04, 3'b010, 32'h1);
        repeat (2) tick();
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, b_bus.gnt, mem_re, mem_we, mem_be, a_bus.rvalid, b_bus.rvalid, a_bus.err, b_bus.err} !== 12'h000)
            $display("FAIL reset_flags got=%b exp=0", {a_bus.gnt, b_bus.gnt, mem_re, mem_we, mem_be, a_bus.rvalid, b_bus.rvalid, a_bus.err, b_bus.err});
        else n_pass++;
        n_total++;
        if ({a_bus.rdata, b_bus.rdata} !== 64'h0)
            $display("FAIL reset_rdata got=%h exp=0", {a_bus.rdata, b_bus.rdata});
        else n_pass++;
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_word_rw();
        drive(1'b0, 1'b1, 1'b1, 'h10, 3'b010, 32'hDEADBEEF);
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, mem_we, mem_re, mem_be} !== 7'b1101111)
            $display("FAIL word_st_ctrl got=%b exp=1101111", {a_bus.gnt, mem_we, mem_re, mem_be});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata} !== {13'd4, 32'hDEADBEEF})
            $display("FAIL word_st_bus got=%h/%h exp=4/deadbeef", mem_addr, mem_wdata);
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, 1'b0, 'h10, 3'b010, 32'h0);
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, mem_re, a_bus.rvalid} !== 3'b110)
            $display("FAIL word_ld_issue got=%b exp=110", {a_bus.gnt, mem_re, a_bus.rvalid});
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, b_bus.rvalid, a_bus.rdata} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL word_ld_data got=%b/%h exp=10/deadbeef", {a_bus.rvalid, b_bus.rvalid}, a_bus.rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_byte_load();
        drive(1'b0, 1'b1, 1'b1, 'h13, 3'b000, 32'h00000080);
        @(negedge clk);
        n_total++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b1000, 32'h80808080})
            $display("FAIL byte_st got=%b/%b/%h exp=1/1000/80808080", mem_we, mem_be, mem_wdata);
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, 1'b0, 'h13, 3'b000, 32'h0);
        @(negedge clk);
        n_total++;
        if ({mem_re, mem_be} !== 5'b11000)
            $display("FAIL byte_ld_be got=%b exp=11000", {mem_re, mem_be});
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, 1'b0, 'h13, 3'b100, 32'h0);
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, a_bus.rdata} !== {1'b1, 32'hFFFFFF80})
            $display("FAIL byte_ld_signed got=%b/%h exp=1/ffffff80", a_bus.rvalid, a_bus.rdata);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, a_bus.rdata} !== {1'b1, 32'h00000080})
            $display("FAIL byte_ld_unsigned got=%b/%h exp=1/00000080", a_bus.rvalid, a_bus.rdata);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, a_bus.rdata} !== 33'h0)
            $display("FAIL idle_rdata got=%b/%h exp=0/0", a_bus.rvalid, a_bus.rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        bit [1:0] exp_g [4];
`ifdef DMEM_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 'h10, 3'b010, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 'h00, 3'b010, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle();
            @(negedge clk);
            if (k < 4) begin
                n_total++;
                if ({a_bus.gnt, b_bus.gnt} !== exp_g[k])
                    $display("FAIL contend_gnt%0d got=%b exp=%b", k, {a_bus.gnt, b_bus.gnt}, exp_g[k]);
                else n_pass++;
            end
            if (k > 0) begin
                n_total++;
                if ({a_bus.rvalid, b_bus.rvalid} !== exp_g[k-1])
                    $display("FAIL contend_rv%0d got=%b exp=%b", k, {a_bus.rvalid, b_bus.rvalid}, exp_g[k-1]);
                else n_pass++;
                if (exp_g[k-1][1]) begin
                    n_total++;
                    if (a_bus.rdata !== 32'h80ADBEEF)
                        $display("FAIL contend_rd%0d got=%h exp=80adbeef", k, a_bus.rdata);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 1'b0, 'h02, 3'b010, 32'h0);
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, mem_re, mem_we, mem_be} !== 7'b1000000)
            $display("FAIL misalign_issue got=%b exp=1000000", {a_bus.gnt, mem_re, mem_we, mem_be});
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 'h00, 3'b011, 32'h0);
        @(negedge clk);
        n_total++;
        if ({a_bus.err, a_bus.rvalid, b_bus.gnt, mem_re, mem_be} !== 8'b10100000)
            $display("FAIL misalign_err got=%b exp=10100000", {a_bus.err, a_bus.rvalid, b_bus.gnt, mem_re, mem_be});
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++;
        if ({a_bus.err, b_bus.err, b_bus.rvalid} !== 3'b010)
            $display("FAIL illegal_size_err got=%b exp=010", {a_bus.err, b_bus.err, b_bus.rvalid});
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({a_bus.err, b_bus.err} !== 2'b00)
            $display("FAIL err_pulse got=%b exp=00", {a_bus.err, b_bus.err});
        else n_pass++;
        tick();
    endtask

    task automatic test_pipelined();
        drive(1'b0, 1'b1, 1'b1, 'h00, 3'b010, 32'h12345678);
        tick();
        drive(1'b0, 1'b1, 1'b0, 'h00, 3'b010, 32'h0);
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, mem_re} !== 2'b11)
            $display("FAIL pipe_ld got=%b exp=11", {a_bus.gnt, mem_re});
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 'h04, 3'b010, 32'hCAFEF00D);
        @(negedge clk);
        n_total++;
        if ({b_bus.gnt, mem_we, mem_addr, a_bus.rvalid, a_bus.rdata} !== {2'b11, 13'd1, 1'b1, 32'h12345678})
            $display("FAIL pipe_overlap got=%b%b/%h/%b/%h exp=11/1/1/12345678", b_bus.gnt, mem_we, mem_addr, a_bus.rvalid, a_bus.rdata);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, b_bus.rvalid} !== 2'b00)
            $display("FAIL store_no_rv got=%b exp=00", {a_bus.rvalid, b_bus.rvalid});
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_during_load();
        drive(1'b0, 1'b1, 1'b0, 'h10, 3'b010, 32'h0);
        @(negedge clk);
        n_total++;
        if (a_bus.gnt !== 1'b1) $display("FAIL rst_ld_gnt got=%b exp=1", a_bus.gnt);
        else n_pass++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, b_bus.gnt, mem_re, mem_we, mem_be, a_bus.rvalid, a_bus.err, a_bus.rdata} !== 41'h0)
            $display("FAIL rst_discard got=%b/%h exp=0/0", {a_bus.gnt, mem_re, mem_we, mem_be, a_bus.rvalid, a_bus.err}, a_bus.rdata);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a_bus.gnt, mem_re, a_bus.rvalid} !== 3'b110)
            $display("FAIL first_gnt got=%b exp=110", {a_bus.gnt, mem_re, a_bus.rvalid});
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++;
        if ({a_bus.rvalid, a_bus.rdata} !== {1'b1, 32'h80ADBEEF})
            $display("FAIL post_rst_ld got=%b/%h exp=1/80adbeef", a_bus.rvalid, a_bus.rdata);
        else n_pass++;
        tick();
    endtask

    // One cycle of the reference model: checks responses owed from the last
    // cycle, then this cycle's arbitration and bank strobes, then books new ones.
    task automatic model_cycle();
        bit          r [2];
        bit          w [2];
        logic [ADDR_W-1:0] ad [2];
        logic [2:0]  sz [2];
        logic [31:0] wd [2];
        int          win, off, width, base;
        bit          ok;
        logic [3:0]  be;
        logic [31:0] val, wexp;
        r[0] = a_bus.req; w[0] = a_bus.we; ad[0] = a_bus.addr; sz[0] = a_bus.size; wd[0] = a_bus.wdata;
        r[1] = b_bus.req; w[1] = b_bus.we; ad[1] = b_bus.addr; sz[1] = b_bus.size; wd[1] = b_bus.wdata;
        n_total++;
        if ({a_bus.rvalid, b_bus.rvalid, a_bus.err, b_bus.err} !== {m_rv[0], m_rv[1], m_err[0], m_err[1]})
            $display("FAIL rnd_resp got=%b exp=%b", {a_bus.rvalid, b_bus.rvalid, a_bus.err, b_bus.err}, {m_rv[0], m_rv[1], m_err[0], m_err[1]});
        else n_pass++;
        if (m_rv[0] || m_rv[1]) begin
            n_total++;
            if ((m_rv[0] ? a_bus.rdata : b_bus.rdata) !== (m_rv[0] ? m_rd[0] : m_rd[1]))
                $display("FAIL rnd_rdata got=%h exp=%h", m_rv[0] ? a_bus.rdata : b_bus.rdata, m_rv[0] ? m_rd[0] : m_rd[1]);
            else n_pass++;
        end
        win = -1;
        if (r[0] && r[1]) begin
`ifdef DMEM_ARB_RR_EN
            win = m_last_b ? 0 : 1;
            m_last_b = (win == 1);
`else
            win = 1;
`endif
        end else if (r[0]) win = 0;
        else if (r[1]) win = 1;
        m_gnt[0] = (win == 0);
        m_gnt[1] = (win == 1);
        n_total++;
        if ({a_bus.gnt, b_bus.gnt} !== {m_gnt[0], m_gnt[1]})
            $display("FAIL rnd_gnt got=%b exp=%b", {a_bus.gnt, b_bus.gnt}, {m_gnt[0], m_gnt[1]});
        else n_pass++;
        m_rv  = '{1'b0, 1'b0};
        m_err = '{1'b0, 1'b0};
        if (win < 0) begin
            n_total++;
            if ({mem_re, mem_we, mem_be} !== 6'b0)
                $display("FAIL rnd_idle_bus got=%b exp=0", {mem_re, mem_we, mem_be});
            else n_pass++;
            return;
        end
        off   = int'(ad[win][1:0]);
        width = (sz[win][1:0] == 2'd0) ? 1 : (sz[win][1:0] == 2'd1) ? 2 : 4;
        ok    = (sz[win] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && (off % width == 0);
        be    = ok ? 4'(((1 << width) - 1) << off) : 4'b0000;
        n_total++;
        if ({mem_re, mem_we, mem_be} !== {ok && !w[win], ok && w[win], be})
            $display("FAIL rnd_strobe got=%b exp=%b sz=%b ad=%h", {mem_re, mem_we, mem_be}, {ok && !w[win], ok && w[win], be}, sz[win], ad[win]);
        else n_pass++;
        m_err[win] = !ok;
        if (!ok) return;
        n_total++;
        if (mem_addr !== ad[win][ADDR_W-1:2])
            $display("FAIL rnd_addr got=%h exp=%h", mem_addr, ad[win][ADDR_W-1:2]);
        else n_pass++;
        base = int'(ad[win][7:0]);
        if (w[win]) begin
            wexp = (width == 1) ? {24'h0, wd[win][7:0]} * 32'h01010101 :
                   (width == 2) ? {16'h0, wd[win][15:0]} * 32'h00010001 : wd[win];
            n_total++;
            if (mem_wdata !== wexp) $display("FAIL rnd_wdata got=%h exp=%h", mem_wdata, wexp);
            else n_pass++;
            for (int i = 0; i < width; i++) ref_mem[base + i] = wd[win][8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < width; i++) val = val | (32'(ref_mem[base + i]) << (8*i));
            if (!sz[win][2] && width < 4 && val[8*width-1]) val = val | ~((32'd1 << (8*width)) - 32'd1);
            m_rv[win] = 1'b1;
            m_rd[win] = val;
        end
    endtask

    task automatic gen_port(input bit port_b);
        bit          rq, we;
        logic [2:0]  sz;
        int          off, width;
        rq = ($urandom_range(0, 9) < 6);
        we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0, 1:    sz = 3'b000;
            2, 3:    sz = 3'b001;
            4, 5:    sz = 3'b010;
            6:       sz = 3'b100;
            7:       sz = 3'b101;
            8:       sz = 3'b011;
            default: sz = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111;
        endcase
        width = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        off = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0) off = off - (off % width);
        drive(port_b, rq, we, ADDR_W'(($urandom_range(0, 15) << 2) + off), sz, $urandom);
    endtask

    task automatic test_random();
        do_reset();
        m_last_b = 1'b0;
        m_gnt = '{1'b0, 1'b0};
        m_rv  = '{1'b0, 1'b0};
        m_err = '{1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b1, ADDR_W'(i * 4), 3'b010, $urandom);
            @(negedge clk);
            model_cycle();
            tick();
        end
        for (int c = 0; c < 400; c++) begin
            if (!(a_bus.req && !m_gnt[0])) gen_port(1'b0);
            if (!(b_bus.req && !m_gnt[1])) gen_port(1'b1);
            @(negedge clk);
            model_cycle();
            tick();
        end
        idle();
        @(negedge clk);
        model_cycle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_word_rw();
        test_byte_load();
        test_contention();
        test_misaligned();
        test_pipelined();
        test_reset_during_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
